// File: rtl/fp32_seq_multiplier_if.sv
// Handshake bundle between a PE (master) and its iterative binary32 multiplier (slave).
// The PE raises input_mul_start and holds it until it has consumed output_done.
interface fp32_seq_multiplier_if;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        input_mul_start;
    logic [31:0] output_mul;
    logic        output_done;
    logic [3:0]  output_flags;

    modport master (
        output input_a, input_b, input_mul_start,
        input  output_mul, output_done, output_flags
    );

    modport slave (
        input  input_a, input_b, input_mul_start,
        output output_mul, output_done, output_flags
    );
endinterface

// File: rtl/fp32_seq_multiplier.sv
// Multi-cycle IEEE-754 binary32 multiplier: shift-add mantissa product, RNE rounding,
// flush-to-zero for denormal inputs and outputs. Flags are {invalid, overflow, underflow, inexact}.
module fp32_seq_multiplier #(
    parameter int BITS_PER_CYCLE = 1
) (
    input logic              clk,
    input logic              rst,
    fp32_seq_multiplier_if.slave bus
);
    localparam int         ITERS    = 24 / BITS_PER_CYCLE;
    localparam logic [4:0] CNT_LAST = 5'(ITERS - 1);

    typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, DONE} state_t;

    state_t state, state_next;

    logic [31:0]        a_r, b_r;
    logic               sign_r;
    logic [47:0]        mcand_r;
    logic [23:0]        mplier_r;
    logic [47:0]        acc_r;
    logic [4:0]         cnt_r;
    logic signed [9:0]  exp_r;
    logic [31:0]        mul_r;
    logic [3:0]         flags_r;

    // Round-to-nearest-even on a product whose leading one sits at bit 46.
    // Returns {flags, result}.
    function automatic logic [35:0] round_pack(input logic sign,
                                               input logic signed [9:0] exp_in,
                                               input logic [47:0] p);
        logic [23:0]       mant;
        logic              g, r, s, up, inexact;
        logic [24:0]       mant_rnd;
        logic signed [9:0] exp_f;
        mant     = p[46:23];
        g        = p[22];
        r        = p[21];
        s        = |p[20:0];
        inexact  = g | r | s;
        up       = g & (r | s | mant[0]);
        mant_rnd = {1'b0, mant} + {24'd0, up};
        exp_f    = exp_in;
        if (mant_rnd[24]) begin
            mant_rnd = mant_rnd >> 1;
            exp_f    = exp_f + 10'sd1;
        end
        if (exp_f >= 10'sd255)
            return {4'b0101, sign, 8'hFF, 23'd0};
        else if (exp_f <= 10'sd0)
            return {4'b0011, sign, 31'd0};
        else
            return {3'b000, inexact, sign, exp_f[7:0], mant_rnd[22:0]};
    endfunction

    logic [7:0]        exp_a, exp_b;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic              is_special, sign_prod;
    logic [31:0]       spec_mul;
    logic [3:0]        spec_flags;
    logic signed [9:0] exp_sum;
    logic [47:0]       partial;
    logic [35:0]       rounded;

    always_comb begin
        exp_a      = a_r[30:23];
        exp_b      = b_r[30:23];
        a_zero     = (exp_a == 8'h00);
        b_zero     = (exp_b == 8'h00);
        a_inf      = (exp_a == 8'hFF) && (a_r[22:0] == 23'd0);
        b_inf      = (exp_b == 8'hFF) && (b_r[22:0] == 23'd0);
        a_nan      = (exp_a == 8'hFF) && (a_r[22:0] != 23'd0);
        b_nan      = (exp_b == 8'hFF) && (b_r[22:0] != 23'd0);
        sign_prod  = a_r[31] ^ b_r[31];
        is_special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
        spec_mul   = {sign_prod, 31'd0};
        spec_flags = 4'b0000;
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
            spec_mul   = 32'h7FC00000;
            spec_flags = 4'b1000;
        end else if (a_inf | b_inf) begin
            spec_mul   = {sign_prod, 8'hFF, 23'd0};
        end
        exp_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;
        partial = mcand_r * {{(48 - BITS_PER_CYCLE){1'b0}}, mplier_r[BITS_PER_CYCLE-1:0]};
        rounded = round_pack(sign_r, exp_r, acc_r);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.input_mul_start) state_next = UNPACK;
            UNPACK:  state_next = is_special ? DONE : MULT;
            MULT:    if (cnt_r == 5'd0) state_next = NORM;
            NORM:    state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (!bus.input_mul_start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            sign_r   <= 1'b0;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            exp_r    <= '0;
            mul_r    <= '0;
            flags_r  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.input_mul_start) begin
                    a_r   <= bus.input_a;
                    b_r   <= bus.input_b;
                    acc_r <= '0;
                end
                UNPACK: begin
                    sign_r   <= sign_prod;
                    mcand_r  <= {24'd0, 1'b1, a_r[22:0]};
                    mplier_r <= {1'b1, b_r[22:0]};
                    cnt_r    <= CNT_LAST;
                    if (is_special) begin
                        mul_r   <= spec_mul;
                        flags_r <= spec_flags;
                    end
                end
                MULT: begin
                    acc_r    <= acc_r + partial;
                    mcand_r  <= mcand_r << BITS_PER_CYCLE;
                    mplier_r <= mplier_r >> BITS_PER_CYCLE;
                    cnt_r    <= cnt_r - 5'd1;
                end
                NORM: begin
                    // Dropped LSB is jammed into bit 0 so it still counts toward sticky.
                    if (acc_r[47]) begin
                        acc_r <= {1'b0, acc_r[47:2], acc_r[1] | acc_r[0]};
                        exp_r <= exp_sum + 10'sd1;
                    end else begin
                        exp_r <= exp_sum;
                    end
                end
                ROUND: begin
                    mul_r   <= rounded[31:0];
                    flags_r <= rounded[35:32];
                end
                default: ;
            endcase
        end
    end

    assign bus.output_mul   = mul_r;
    assign bus.output_flags = flags_r;
    assign bus.output_done  = (state == DONE);
endmodule

// File: tb/tb_fp32_seq_multiplier.sv
// Directed bench for fp32_seq_multiplier: one instance at 1 bit/cycle, one at 8 bits/cycle.
module tb_fp32_seq_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fp32_seq_multiplier_if bus1 ();
    fp32_seq_multiplier_if bus8 ();

    fp32_seq_multiplier #(.BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    fp32_seq_multiplier #(.BITS_PER_CYCLE(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [31:0] a, input logic [31:0] b, input logic s);
        if (sel == 8) begin
            bus8.input_a = a; bus8.input_b = b; bus8.input_mul_start = s;
        end else begin
            bus1.input_a = a; bus1.input_b = b; bus1.input_mul_start = s;
        end
    endtask

    task automatic set_start(input int sel, input logic s);
        if (sel == 8) bus8.input_mul_start = s;
        else          bus1.input_mul_start = s;
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 8) ? bus8.output_done : bus1.output_done;
    endfunction

    function automatic logic [31:0] get_mul(input int sel);
        return (sel == 8) ? bus8.output_mul : bus1.output_mul;
    endfunction

    function automatic logic [31:0] get_flags(input int sel);
        return {28'd0, (sel == 8) ? bus8.output_flags : bus1.output_flags};
    endfunction

    // Steps edges first_edge, first_edge+1, ... and reports the edge after which done is seen (-1 on timeout).
    task automatic wait_done(input int sel, input int first_edge, output int edge_no);
        edge_no = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (get_done(sel)) begin
                edge_no = first_edge + i;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_mul, input logic [3:0] exp_flags, input int exp_edge);
        int e;
        drive(sel, a, b, 1'b1);
        wait_done(sel, 0, e);
        chk({tag, "_latency"}, 32'(e), 32'(exp_edge));
        chk({tag, "_mul"}, get_mul(sel), exp_mul);
        chk({tag, "_flags"}, get_flags(sel), {28'd0, exp_flags});
        set_start(sel, 1'b0);
        step();
        chk({tag, "_done_fall"}, {31'd0, get_done(sel)}, 32'd0);
    endtask

    initial begin
        int e;
        drive(1, 32'h0, 32'h0, 1'b0);
        drive(8, 32'h0, 32'h0, 1'b0);
        #2;
        chk("reset_mul", bus1.output_mul, 32'h0);
        chk("reset_done", {31'd0, bus1.output_done}, 32'd0);
        chk("reset_flags", {28'd0, bus1.output_flags}, 32'd0);
        step();
        rst = 1'b0;
        step();

        run_op("basic", 1, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 27);
        chk("hold_in_idle", bus1.output_mul, 32'h40C00000);

        // Operands are scrambled right after the accept edge and start is held past done.
        drive(1, 32'h3FC00000, 32'hBFC00000, 1'b1);
        step();
        drive(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_done(1, 1, e);
        chk("sign_latency", 32'(e), 32'd27);
        chk("sign_mul", bus1.output_mul, 32'hC0100000);
        chk("sign_flags", {28'd0, bus1.output_flags}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_done", {31'd0, bus1.output_done}, 32'd1);
            chk("hold_mul", bus1.output_mul, 32'hC0100000);
        end
        set_start(1, 1'b0);
        step();
        chk("hold_done_fall", {31'd0, bus1.output_done}, 32'd0);

        run_op("round1", 1, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 27);
        run_op("round8", 8, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 6);
        run_op("basic8", 8, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 6);
        run_op("overflow", 1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 27);
        run_op("underflow", 1, 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 27);
        run_op("inf_x_zero", 1, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1);
        run_op("neg_inf", 1, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1);
        run_op("neg_zero", 1, 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 1);
        run_op("nan", 1, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000, 1);

        // Start withdrawn mid-operation: result still completes, done pulses for one cycle.
        drive(1, 32'h3FC00000, 32'h3FC00000, 1'b1);
        step();
        step();
        step();
        set_start(1, 1'b0);
        wait_done(1, 3, e);
        chk("pulse_latency", 32'(e), 32'd27);
        chk("pulse_mul", bus1.output_mul, 32'h40100000);
        step();
        chk("pulse_done_fall", {31'd0, bus1.output_done}, 32'd0);

        // Reset asserted between edges partway through an operation.
        drive(1, 32'h40000000, 32'h40400000, 1'b1);
        for (int i = 0; i <= 10; i++) step();
        #2;
        rst = 1'b1;
        set_start(1, 1'b0);
        #1;
        chk("midrst_mul", bus1.output_mul, 32'h0);
        chk("midrst_done", {31'd0, bus1.output_done}, 32'd0);
        chk("midrst_flags", {28'd0, bus1.output_flags}, 32'd0);
        #2;
        rst = 1'b0;
        step();
        run_op("after_rst", 1, 32'h40400000, 32'h40400000, 32'h41100000, 4'b0000, 27);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
